// File: rtl/pc_predict_unit.sv
// pc_predict_unit: fetch-PC register with a direct-mapped BTB and 2-bit
// saturating counters. Predicts the next fetch PC in zero cycles, resolves
// the prediction against the X-stage outcome, raises a combinational flush
// on mispredict and keeps resolved-transfer / mispredict statistics.
`timescale 1ns/1ps
module pc_predict_unit #(
    parameter int               WIDTH     = 32,
    parameter int               BTB_DEPTH = 16,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter int               PREDICT   = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    output logic [WIDTH-1:0] F_pc,
    output logic             F_pred_taken,
    output logic [WIDTH-1:0] F_pred_target,
    input  logic             X_valid,
    input  logic [WIDTH-1:0] X_pc,
    input  logic             X_is_branch,
    input  logic             X_is_jump,
    input  logic             X_taken,
    input  logic [WIDTH-1:0] X_target,
    input  logic             X_pred_taken,
    input  logic [WIDTH-1:0] X_pred_target,
    output logic             flush,
    output logic [WIDTH-1:0] branch_count,
    output logic [WIDTH-1:0] mispredict_count
);

    localparam int               IDX     = $clog2(BTB_DEPTH);
    localparam int               TAG_W   = WIDTH - IDX;
    localparam bit               PRED_EN = (PREDICT != 0);
    localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);

    // Counter encodings: 00/01 predict not-taken, 10/11 predict taken.
    localparam logic [1:0] CTR_RESET  = 2'b01;
    localparam logic [1:0] CTR_WEAK_T = 2'b10;
    localparam logic [1:0] CTR_STRONG = 2'b11;

    // Saturating increment of a 2-bit confidence counter.
    function automatic logic [1:0] ctr_sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    // Saturating decrement of a 2-bit confidence counter.
    function automatic logic [1:0] ctr_sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    // BTB storage: valid/counter are control state and get reset;
    // tag/target are payload only ever read behind a set valid bit.
    logic [BTB_DEPTH-1:0] btb_valid;
    logic [1:0]           btb_ctr    [BTB_DEPTH];
    logic [TAG_W-1:0]     btb_tag    [BTB_DEPTH];
    logic [WIDTH-1:0]     btb_target [BTB_DEPTH];

    logic [IDX-1:0]   f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;

    logic [IDX-1:0]   x_idx;
    logic [TAG_W-1:0] x_tag;
    logic             x_hit;
    logic             x_ctrl;
    logic             x_actual_taken;
    logic [WIDTH-1:0] x_correct_next;
    logic             x_update;

    logic [WIDTH-1:0] pc_next;

    // The recorded prediction bit is implied by X_pred_target; keep it
    // on the port for the pipeline but it does not influence resolution.
    logic unused_x_pred_taken;
    assign unused_x_pred_taken = X_pred_taken;

    // F-stage lookup: sees BTB contents before any same-cycle update.
    always_comb begin
        f_idx         = F_pc[IDX-1:0];
        f_tag         = F_pc[WIDTH-1:IDX];
        f_hit         = PRED_EN && btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
        F_pred_taken  = f_hit && btb_ctr[f_idx][1];
        F_pred_target = F_pred_taken ? btb_target[f_idx] : F_pc + ONE_W;
    end

    // X-stage resolution: compare the real next PC with the one predicted.
    always_comb begin
        x_idx          = X_pc[IDX-1:0];
        x_tag          = X_pc[WIDTH-1:IDX];
        x_hit          = btb_valid[x_idx] && (btb_tag[x_idx] == x_tag);
        x_ctrl         = X_is_branch || X_is_jump;
        x_actual_taken = X_is_jump || (X_is_branch && X_taken);
        x_correct_next = x_actual_taken ? X_target : X_pc + ONE_W;
        x_update       = X_valid && x_ctrl;
        flush          = X_valid && (x_correct_next != X_pred_target);
    end

    // Next fetch PC: redirect beats stall, stall beats prediction.
    always_comb begin
        if (flush) begin
            pc_next = x_correct_next;
        end else if (stall) begin
            pc_next = F_pc;
        end else begin
            pc_next = F_pred_target;
        end
    end

    // Fetch PC register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            F_pc <= RESET_PC;
        end else begin
            F_pc <= pc_next;
        end
    end

    // BTB control state: valid bits and confidence counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            btb_valid <= '0;
            for (int i = 0; i < BTB_DEPTH; i++) begin
                btb_ctr[i] <= CTR_RESET;
            end
        end else if (PRED_EN && x_update) begin
            if (x_hit) begin
                if (X_is_jump) begin
                    btb_ctr[x_idx] <= CTR_STRONG;
                end else if (X_taken) begin
                    btb_ctr[x_idx] <= ctr_sat_inc(btb_ctr[x_idx]);
                end else begin
                    btb_ctr[x_idx] <= ctr_sat_dec(btb_ctr[x_idx]);
                end
            end else if (x_actual_taken) begin
                // Allocation replaces whatever aliased entry was there.
                btb_valid[x_idx] <= 1'b1;
                btb_ctr[x_idx]   <= X_is_jump ? CTR_STRONG : CTR_WEAK_T;
            end
        end
    end

    // BTB payload: any taken transfer (re)writes tag and target.
    always_ff @(posedge clock) begin
        if (PRED_EN && x_update && x_actual_taken) begin
            btb_tag[x_idx]    <= x_tag;
            btb_target[x_idx] <= X_target;
        end
    end

    // Statistics: resolved control transfers and mispredicts, wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (x_update) begin
                branch_count <= branch_count + ONE_W;
            end
            if (flush) begin
                mispredict_count <= mispredict_count + ONE_W;
            end
        end
    end

endmodule

// File: tb/tb_pc_predict_unit.sv
// Testbench for pc_predict_unit: a BTB-predicting instance and a static
// not-taken instance share one stimulus stream; a reference model pushes
// expected outputs into a queue and a monitor pops and compares them.
`timescale 1ns/1ps
module tb_pc_predict_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        X_valid;
    logic [31:0] X_pc;
    logic        X_is_branch;
    logic        X_is_jump;
    logic        X_taken;
    logic [31:0] X_target;
    logic        X_pred_taken;
    logic [31:0] X_pred_target;

    logic [31:0] a_F_pc, a_F_pred_target, a_bc, a_mc;
    logic        a_F_pred_taken, a_flush;
    logic [31:0] s_F_pc, s_F_pred_target, s_bc, s_mc;
    logic        s_F_pred_taken, s_flush;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    pc_predict_unit #(.WIDTH(32), .BTB_DEPTH(16), .RESET_PC(32'h100), .PREDICT(1)) dut_btb (
        .clock(clock), .reset(reset), .stall(stall),
        .F_pc(a_F_pc), .F_pred_taken(a_F_pred_taken), .F_pred_target(a_F_pred_target),
        .X_valid(X_valid), .X_pc(X_pc), .X_is_branch(X_is_branch), .X_is_jump(X_is_jump),
        .X_taken(X_taken), .X_target(X_target), .X_pred_taken(X_pred_taken),
        .X_pred_target(X_pred_target), .flush(a_flush),
        .branch_count(a_bc), .mispredict_count(a_mc)
    );

    pc_predict_unit #(.WIDTH(32), .BTB_DEPTH(16), .RESET_PC(32'h100), .PREDICT(0)) dut_static (
        .clock(clock), .reset(reset), .stall(stall),
        .F_pc(s_F_pc), .F_pred_taken(s_F_pred_taken), .F_pred_target(s_F_pred_target),
        .X_valid(X_valid), .X_pc(X_pc), .X_is_branch(X_is_branch), .X_is_jump(X_is_jump),
        .X_taken(X_taken), .X_target(X_target), .X_pred_taken(X_pred_taken),
        .X_pred_target(X_pred_target), .flush(s_flush),
        .branch_count(s_bc), .mispredict_count(s_mc)
    );

    typedef struct {
        int          m;
        logic [31:0] pc;
        logic        pt;
        logic [31:0] ptg;
        logic        fl;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t q[$];

    // Reference model state: index 0 = BTB instance, 1 = static instance.
    logic [31:0] mpc [2];
    logic [31:0] mbc [2];
    logic [31:0] mmc [2];
    bit          bv   [16];
    logic [31:0] btag [16];
    logic [31:0] btgt [16];
    int          bctr [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mpc[m] = 32'h100;
            mbc[m] = 0;
            mmc[m] = 0;
        end
        for (int i = 0; i < 16; i++) begin
            bv[i]   = 1'b0;
            bctr[i] = 1;
        end
    endtask

    task automatic btb_learn(input logic [31:0] xpc, input bit isj, input bit taken,
                             input logic [31:0] tgt);
        int          idx;
        logic [31:0] tag;
        idx = int'(xpc % 32'd16);
        tag = xpc / 32'd16;
        if (bv[idx] && btag[idx] == tag) begin
            if (isj)        bctr[idx] = 3;
            else if (taken) bctr[idx] = (bctr[idx] >= 3) ? 3 : bctr[idx] + 1;
            else            bctr[idx] = (bctr[idx] <= 0) ? 0 : bctr[idx] - 1;
            if (taken) btgt[idx] = tgt;
        end else if (taken) begin
            bv[idx]   = 1'b1;
            btag[idx] = tag;
            btgt[idx] = tgt;
            bctr[idx] = isj ? 3 : 2;
        end
    endtask

    // One cycle of stimulus: drive inputs, push expected outputs, advance model.
    task automatic step(input bit rv, input bit st, input bit xv, input logic [31:0] xpc,
                        input bit isb, input bit isj, input bit tk,
                        input logic [31:0] tgt, input logic [31:0] ptgt);
        exp_t        e;
        logic [31:0] cn, ptg, tag;
        bit          taken, fl, hit, ptk;
        int          idx;
        @(posedge clock);
        #2;
        reset         = rv;
        stall         = st;
        X_valid       = xv;
        X_pc          = xpc;
        X_is_branch   = isb;
        X_is_jump     = isj;
        X_taken       = tk;
        X_target      = tgt;
        X_pred_target = ptgt;
        X_pred_taken  = (ptgt != xpc + 32'd1);
        if (!rv) model_reset();
        taken = isj || (isb && tk);
        cn    = taken ? tgt : xpc + 32'd1;
        fl    = xv && (cn != ptgt);
        for (int m = 0; m < 2; m++) begin
            idx   = int'(mpc[m] % 32'd16);
            tag   = mpc[m] / 32'd16;
            hit   = (m == 0) && bv[idx] && (btag[idx] == tag);
            ptk   = hit && (bctr[idx] >= 2);
            ptg   = ptk ? btgt[idx] : mpc[m] + 32'd1;
            e.m   = m;
            e.pc  = mpc[m];
            e.pt  = ptk;
            e.ptg = ptg;
            e.fl  = fl;
            e.bc  = mbc[m];
            e.mc  = mmc[m];
            q.push_back(e);
            if (rv) begin
                mpc[m] = fl ? cn : (st ? mpc[m] : ptg);
                if (xv && (isb || isj)) mbc[m] = mbc[m] + 32'd1;
                if (fl) mmc[m] = mmc[m] + 32'd1;
            end
        end
        if (rv && xv && (isb || isj)) btb_learn(xpc, isj, taken, tgt);
    endtask

    task automatic idle(input bit st);
        step(1'b1, st, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1);
    endtask

    // Non-control instruction with a wrong recorded next PC: redirects F to pc.
    task automatic redirect(input logic [31:0] pc, input bit st);
        step(1'b1, st, 1'b1, pc - 32'd1, 1'b0, 1'b0, 1'b0, 32'h0, ~pc);
    endtask

    task automatic resolve(input logic [31:0] xpc, input bit isb, input bit isj, input bit tk,
                           input logic [31:0] tgt, input logic [31:0] ptgt);
        step(1'b1, 1'b0, 1'b1, xpc, isb, isj, tk, tgt, ptgt);
    endtask

    // Move to just after the falling edge of the current cycle.
    task automatic peek();
        #4;
    endtask

    // Monitor: every falling edge, compare both instances against the queue.
    initial begin
        exp_t        e;
        logic [31:0] apc, aptg, abc, amc;
        logic        apt, afl;
        string       nm;
        forever begin
            @(negedge clock);
            while (q.size() > 0) begin
                e = q.pop_front();
                if (e.m == 0) begin
                    apc = a_F_pc; apt = a_F_pred_taken; aptg = a_F_pred_target;
                    afl = a_flush; abc = a_bc; amc = a_mc;
                    nm  = "btb";
                end else begin
                    apc = s_F_pc; apt = s_F_pred_taken; aptg = s_F_pred_target;
                    afl = s_flush; abc = s_bc; amc = s_mc;
                    nm  = "static";
                end
                chk({nm, "_F_pc"},          apc,        e.pc);
                chk({nm, "_F_pred_taken"},  32'(apt),   32'(e.pt));
                chk({nm, "_F_pred_target"}, aptg,       e.ptg);
                chk({nm, "_flush"},         32'(afl),   32'(e.fl));
                chk({nm, "_branch_count"},  abc,        e.bc);
                chk({nm, "_mispred_count"}, amc,        e.mc);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] xpc, tgt, ptgt, cn;
        bit          xv, isb, isj, tk, st;
        int          r;

        reset = 1'b0; stall = 1'b0; X_valid = 1'b0; X_pc = '0; X_is_branch = 1'b0;
        X_is_jump = 1'b0; X_taken = 1'b0; X_target = '0; X_pred_taken = 1'b0;
        X_pred_target = '0;
        model_reset();

        // Reset, then free-running sequential fetch.
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1);
        for (int i = 0; i < 4; i++) begin
            idle(1'b0); peek();
            chk("seq_F_pc", a_F_pc, 32'h100 + 32'(i));
            chk("seq_branch_count", a_bc, 32'h0);
        end

        // Loop branch 0x10 -> 0x08 taken three times.
        resolve(32'h10, 1'b1, 1'b0, 1'b1, 32'h08, 32'h11); peek();
        chk("loop_first_flush", 32'(a_flush), 32'd1);
        resolve(32'h10, 1'b1, 1'b0, 1'b1, 32'h08, 32'h08);
        resolve(32'h10, 1'b1, 1'b0, 1'b1, 32'h08, 32'h08);
        redirect(32'h10, 1'b0); peek();
        chk("loop_branch_count", a_bc, 32'd3);
        chk("loop_mispred_count", a_mc, 32'd1);
        idle(1'b0); peek();
        chk("loop_fetch_pc", a_F_pc, 32'h10);
        chk("loop_pred_taken", 32'(a_F_pred_taken), 32'd1);
        chk("loop_pred_target", a_F_pred_target, 32'h08);

        // Not-taken at strong counter, twice.
        resolve(32'h10, 1'b1, 1'b0, 1'b0, 32'h08, 32'h08); peek();
        chk("nt_flush", 32'(a_flush), 32'd1);
        idle(1'b0); peek();
        chk("nt_redirect_pc", a_F_pc, 32'h11);
        resolve(32'h10, 1'b1, 1'b0, 1'b0, 32'h08, 32'h08);
        redirect(32'h10, 1'b0);
        idle(1'b0); peek();
        chk("nt_weak_pred_taken", 32'(a_F_pred_taken), 32'd0);
        chk("nt_weak_pred_target", a_F_pred_target, 32'h11);

        // Flush overrides stall; stall alone holds.
        redirect(32'h30, 1'b1);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1); peek();
            chk("stall_hold_pc", a_F_pc, 32'h30);
        end

        // Aliasing: 0x13 evicts 0x03's entry.
        resolve(32'h03, 1'b1, 1'b0, 1'b1, 32'h20, 32'h04);
        resolve(32'h13, 1'b0, 1'b1, 1'b0, 32'h30, 32'h14);
        redirect(32'h03, 1'b0);
        idle(1'b0); peek();
        chk("alias_pred_taken", 32'(a_F_pred_taken), 32'd0);
        chk("alias_pred_target", a_F_pred_target, 32'h04);

        // Static instance: taken jump redirects, never predicts taken.
        resolve(32'h05, 1'b0, 1'b1, 1'b0, 32'h40, 32'h06); peek();
        chk("static_flush", 32'(s_flush), 32'd1);
        idle(1'b0); peek();
        chk("static_redirect_pc", s_F_pc, 32'h40);
        chk("static_pred_taken", 32'(s_F_pred_taken), 32'd0);

        // PC wrap at the top of the address space.
        redirect(32'hFFFF_FFFF, 1'b0);
        idle(1'b0); peek();
        chk("wrap_pc", a_F_pc, 32'hFFFF_FFFF);
        chk("wrap_pred_target", a_F_pred_target, 32'h0);

        // Randomized traffic with a mid-run asynchronous reset.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500 || i == 1501) begin
                step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1);
                continue;
            end
            xv  = ($urandom_range(0, 3) != 0);
            xpc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                              : 32'($urandom_range(0, 63));
            r   = int'($urandom_range(0, 3));
            isb = (r == 1) || (r == 3);
            isj = (r == 2);
            tk  = $urandom_range(0, 1) != 0;
            tgt = 32'($urandom_range(0, 63));
            st  = ($urandom_range(0, 4) == 0);
            cn  = (isj || (isb && tk)) ? tgt : xpc + 32'd1;
            r   = int'($urandom_range(0, 2));
            ptgt = (r == 0) ? xpc + 32'd1 : (r == 1) ? cn : 32'($urandom_range(0, 63));
            step(1'b1, st, xv, xpc, isb, isj, tk, tgt, ptgt);
        end

        idle(1'b0);
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clock);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_predict_unit.md
# pc_predict_unit

Parametrised fetch-PC unit for the 5-stage pipeline: holds the fetch PC and predicts the next PC from a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It resolves predictions against X-stage outcomes, raises `flush` and redirects on mispredict, and keeps branch/mispredict statistics. It sits between the F-stage instruction-memory address and the X-stage branch-resolution logic, which supplies decoded taken/target results.

## Interface
- `WIDTH`, 32, PC/target width (PC is word-addressed, increments by 1)
- `BTB_DEPTH`, 16, BTB entries; power of two, ≥2; `IDX = log2(BTB_DEPTH)`
- `RESET_PC`, 0, PC value loaded on reset
- `PREDICT`, 1, 1 = BTB prediction; 0 = static not-taken (BTB never consulted or written)

Ports:
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = reset)
- `stall`  in  1  hold F-stage PC this cycle
- `F_pc`  out  WIDTH  current fetch PC (registered)
- `F_pred_taken`  out  1  prediction for `F_pc`, carried down the pipeline
- `F_pred_target`  out  WIDTH  predicted next PC for `F_pc`, carried down the pipeline
- `X_valid`  in  1  X stage holds a real (non-bubble) instruction
- `X_pc`  in  WIDTH  PC of the X-stage instruction
- `X_is_branch`  in  1  conditional branch (bne, blt)
- `X_is_jump`  in  1  unconditional control transfer (j, jal, jr, taken bex)
- `X_taken`  in  1  conditional branch condition resolved true
- `X_target`  in  WIDTH  resolved target
- `X_pred_taken`  in  WIDTH=1  prediction recorded for that instruction
- `X_pred_target`  in  WIDTH  predicted next PC recorded for that instruction
- `flush`  out  1  mispredict: squash F/D (combinational)
- `branch_count`  out  WIDTH  resolved control transfers since reset
- `mispredict_count`  out  WIDTH  mispredicts since reset

## Operation
- Lookup (comb, on `F_pc`): index = `F_pc[IDX-1:0]`, tag = `F_pc[WIDTH-1:IDX]`. Hit = valid & tag match. `F_pred_taken` = hit & ctr[1]. `F_pred_target` = taken ? stored target : `F_pc`+1 (mod 2^WIDTH). With PREDICT=0: taken=0, target=`F_pc`+1.
- Resolution: actual_taken = `X_is_jump` | (`X_is_branch` & `X_taken`); correct_next = actual_taken ? `X_target` : `X_pc`+1.
- `flush` = `X_valid` & (correct_next ≠ `X_pred_target`). Non-control instructions with `X_pred_target` = `X_pc`+1 never flush; a stale taken prediction on a non-branch does flush.
- Next PC priority: flush → correct_next; else `stall` → hold; else `F_pred_target`.
- BTB update (edge, only when PREDICT=1 and `X_valid` & (`X_is_branch`|`X_is_jump`)), entry at `X_pc` index:
  - hit, jump: ctr←11, target←`X_target`
  - hit, branch: ctr saturating +1 if taken, −1 if not; target←`X_target` if taken
  - miss, actual_taken: allocate valid=1, tag, target; ctr←11 for jump, 10 for branch
  - miss, not taken: no change
- Stats: `branch_count` +1 per update-qualifying cycle (also with PREDICT=0); `mispredict_count` +1 per `flush` cycle; both wrap at 2^WIDTH.

## Timing
- Reset (async, `reset`=0): `F_pc`=RESET_PC, all valid=0, all ctr=01, both counters=0; `flush`, `F_pred_taken` then 0 (no `X_valid` assumed during reset); `F_pred_target`=RESET_PC+1. Deassertion mid-operation is handled only by the external reset synchroniser; reset mid-stall/mid-flush discards everything.
- Redirect latency: flush seen in cycle N, `F_pc`=correct_next in N+1. Flush overrides `stall`.
- Prediction is zero-latency: `F_pc` in N, predicted PC in `F_pc` at N+1 (if not stalled).
- Same-cycle update and lookup of one index: lookup sees pre-update contents; update visible next cycle.
- Counter saturation: 11 stays 11 on taken, 00 stays 00 on not-taken.
- PC wrap: `F_pc`=2^WIDTH−1 predicts 0 when not taken.

## Test plan
- Reset with RESET_PC=0x100, then 4 cycles no stall → `F_pc` 0x100,0x101,0x102,0x103; `flush`=0; counters 0.
- Loop branch at PC 0x10 → 0x08, resolved taken 3 times → 1st resolution flushes (miss, pred not-taken), allocates ctr=10; next fetch of 0x10 predicts 0x08; `mispredict_count`=1, `branch_count`=3.
- Same branch then not-taken at ctr=11 → flush, `F_pc`=0x11 next cycle, ctr=10; second not-taken → ctr=01, next fetch predicts 0x11.
- `stall`=1 with simultaneous mispredict → `F_pc` takes correct_next anyway; `stall`=1 alone holds `F_pc` for 3 cycles.
- Two PCs aliasing same index (BTB_DEPTH=16: 0x03, 0x13) → 0x13 taken evicts 0x03's entry; fetch of 0x03 then misses, predicts 0x04.
- PREDICT=0, taken jump to 0x40 from 0x05 → flush every taken transfer, `F_pred_taken` always 0, BTB unchanged; `F_pc`=0x40 next cycle.
